// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the HD44780 LCD controller.
//   lcd_state_t  - controller FSM states
//   INIT_ROM     - power-up command sequence (all RS=0), INIT_LEN entries
//   BIT_*        - field positions inside the LSU LCD register word
//   is_long_cmd  - true for clear/home commands that need the long wait
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT_LOAD,
    ST_SETUP,
    ST_EN_HI,
    ST_HOLD,
    ST_EXEC,
    ST_IDLE
  } lcd_state_t;

  localparam int unsigned INIT_LEN = 4;
  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{8'h38, 8'h0C, 8'h06, 8'h01};

  localparam int unsigned BIT_ON   = 31;
  localparam int unsigned BIT_REQ  = 10;
  localparam int unsigned BIT_RS   = 9;
  localparam int unsigned DATA_MSB = 7;
  localparam int unsigned DATA_LSB = 0;

  // Clear display (0x01) and return home (0x02/0x03) are the slow commands.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data[7:2] == '0) && (data != '0);
  endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// lcd_delay_cnt: loadable down-counter shared by all timed FSM states.
//   i_clk, i_reset - clock, asynchronous active-high reset (counter -> RST_VAL)
//   load, value    - load value on the next edge (N-1 gives an N-cycle state)
//   zero           - counter has reached 0; it then holds at 0
module lcd_delay_cnt #(
  parameter int unsigned W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)          cnt <= RST_VAL;
    else if (load)        cnt <= value;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780 character LCD bus sequencer.
//   i_clk, i_reset - clock, asynchronous active-high reset
//   i_lcd_word     - LSU LCD register: [31] panel on, [10] request toggle,
//                    [9] RS, [7:0] data
//   o_lcd_data/rs/rw/en - LCD bus pins (write-only, rw tied low)
//   o_lcd_on       - registered copy of [31]
//   o_busy         - low only while idle and ready for a request
// After reset: power-up wait, four init commands, then one timed write
// (setup, EN pulse, hold, execution wait) per toggle of the request bit.
module lcd_ctrl #(
  parameter int unsigned T_PWRUP     = 2_000_000,
  parameter int unsigned T_SETUP     = 4,
  parameter int unsigned T_EN        = 12,
  parameter int unsigned T_HOLD      = 4,
  parameter int unsigned T_EXEC      = 2_000,
  parameter int unsigned T_EXEC_LONG = 82_000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_lcd_word,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic        o_busy
);
  import lcd_pkg::*;

  localparam int unsigned CNT_MAX = (T_PWRUP > T_EXEC_LONG) ? T_PWRUP : T_EXEC_LONG;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int unsigned IDX_W   = $clog2(INIT_LEN) + 1;

  lcd_state_t       state, state_nxt;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;
  logic [IDX_W-1:0] init_idx;
  logic             req_seen;
  logic             capture;
  logic             rom_load;

  logic unused_word_bits;
  assign unused_word_bits = ^{i_lcd_word[30:11], i_lcd_word[8]};

  // Reset value covers the power-up state, which is entered without a load.
  lcd_delay_cnt #(
    .W       (CNT_W),
    .RST_VAL (CNT_W'(T_PWRUP - 1))
  ) u_delay (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .load    (cnt_load),
    .value   (cnt_val),
    .zero    (cnt_zero)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= ST_PWRUP;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    capture   = 1'b0;
    rom_load  = 1'b0;
    case (state)
      ST_PWRUP: begin
        if (cnt_zero) state_nxt = ST_INIT_LOAD;
      end
      ST_INIT_LOAD: begin
        rom_load  = 1'b1;
        cnt_load  = 1'b1;
        cnt_val   = CNT_W'(T_SETUP - 1);
        state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          cnt_load  = 1'b1;
          cnt_val   = CNT_W'(T_EN - 1);
          state_nxt = ST_EN_HI;
        end
      end
      ST_EN_HI: begin
        if (cnt_zero) begin
          cnt_load  = 1'b1;
          cnt_val   = CNT_W'(T_HOLD - 1);
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          cnt_load  = 1'b1;
          cnt_val   = is_long_cmd(o_lcd_rs, o_lcd_data) ? CNT_W'(T_EXEC_LONG - 1)
                                                        : CNT_W'(T_EXEC - 1);
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // init_idx has already advanced past the entry just issued.
        if (cnt_zero)
          state_nxt = (init_idx < IDX_W'(INIT_LEN)) ? ST_INIT_LOAD : ST_IDLE;
      end
      ST_IDLE: begin
        if (i_lcd_word[BIT_REQ] != req_seen) begin
          capture   = 1'b1;
          cnt_load  = 1'b1;
          cnt_val   = CNT_W'(T_SETUP - 1);
          state_nxt = ST_SETUP;
        end
      end
      default: state_nxt = ST_PWRUP;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_lcd_data <= '0;
      o_lcd_rs   <= 1'b0;
      o_lcd_on   <= 1'b0;
      req_seen   <= 1'b0;
      init_idx   <= '0;
    end else begin
      o_lcd_on <= i_lcd_word[BIT_ON];
      if (rom_load) begin
        o_lcd_data <= INIT_ROM[init_idx[IDX_W-2:0]];
        o_lcd_rs   <= 1'b0;
        init_idx   <= init_idx + 1'b1;
      end else if (capture) begin
        o_lcd_data <= i_lcd_word[DATA_MSB:DATA_LSB];
        o_lcd_rs   <= i_lcd_word[BIT_RS];
        req_seen   <= i_lcd_word[BIT_REQ];
      end
    end
  end

  assign o_lcd_rw = 1'b0;
  assign o_lcd_en = (state == ST_EN_HI);
  assign o_busy   = (state != ST_IDLE);

endmodule
